// File: rtl/disp_pkg.sv
//------------------------------------------------------------------------------
// Module  : disp_pkg
// Brief   : Shared 7-segment codes and FSM state type for bcd_seg_display.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package disp_pkg;

  // Active-high {gfedcba} codes; the top applies board polarity.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_enc.sv
//------------------------------------------------------------------------------
// Module  : seg7_enc
// Brief   : Combinational BCD digit to active-high 7-segment code with blank.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_enc
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_seg_display.sv
//------------------------------------------------------------------------------
// Module  : bcd_seg_display
// Brief   : Binary to multi-digit 7-segment driver using an iterative
//           double-dabble engine behind a valid/ready handshake.
//           Optional macro LZ_BLANK_EN blanks leading-zero digits.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_seg_display
  import disp_pkg::*;
#(
  parameter int BIN_W       = 8,
  parameter int DIGITS      = 3,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_value,
  output logic [7*DIGITS-1:0]   seg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  out_valid
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_scr_w = c_bcd_w + 4;
  localparam int c_cnt_w = $clog2(BIN_W + 1);
  localparam logic [c_cnt_w-1:0]  c_last    = c_cnt_w'(BIN_W - 1);
  localparam logic [7*DIGITS-1:0] c_seg_off = (SEG_ACT_LOW != 0) ? '1 : '0;

  fsm_state_t            r_state;
  logic [BIN_W-1:0]      r_bin;
  logic [c_scr_w-1:0]    r_scr;
  logic                  r_carry;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_bcd_w-1:0]    r_bcd;
  logic                  r_ovf;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic [7*DIGITS-1:0]   r_seg;

  logic [c_scr_w-1:0]    w_adj;
  logic [c_scr_w-1:0]    w_shift;
  logic                  w_ovf;
  logic [c_bcd_w-1:0]    w_load_bcd;
  logic [c_bcd_w-1:0]    w_bcd_src;
  logic [DIGITS-1:0]     w_lz;
  logic [7*DIGITS-1:0]   w_seg_raw;

  // Add-3 correction on every nibble, including the overflow guard nibble.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_shift    = {w_adj[c_scr_w-2:0], r_bin[BIN_W-1]};
  // Any bit that ever left the scratch, or a live guard nibble, means >= 10^DIGITS.
  assign w_ovf      = r_carry | (r_scr[c_scr_w-1 -: 4] != 4'd0);
  assign w_load_bcd = w_ovf ? {DIGITS{4'h9}} : r_scr[c_bcd_w-1:0];
  // Segments track the value bcd holds after this edge, so both update together.
  assign w_bcd_src  = (r_state == LOAD) ? w_load_bcd : r_bcd;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_units
        assign w_lz[gi] = 1'b0;
      end else begin : g_upper
`ifdef LZ_BLANK_EN
        assign w_lz[gi] = (w_bcd_src[c_bcd_w-1:4*gi] == '0);
`else
        assign w_lz[gi] = 1'b0;
`endif
      end

      seg7_enc u_enc (
        .bcd   (w_bcd_src[4*gi +: 4]),
        .blank (~en | w_lz[gi]),
        .seg   (w_seg_raw[7*gi +: 7])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_scr       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_seg       <= c_seg_off;
    end else begin
      r_out_valid <= 1'b0;
      r_seg       <= w_seg_raw ^ c_seg_off;
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_bin      <= in_value;
            r_scr      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_scr   <= w_shift;
          r_carry <= r_carry | w_adj[c_scr_w-1];
          r_bin   <= r_bin << 1;
          r_cnt   <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_bcd       <= w_load_bcd;
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign seg       = r_seg;
  assign bcd       = r_bcd;
  assign overflow  = r_ovf;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire
